// File: rtl/adc_seq_ctrl.sv
// adc_seq_ctrl: round-robin ADC channel sequencer that re-tags one-frame-late results into a valid/ready holding register
module adc_seq_ctrl #(
    parameter int BYTE_W = 8,
    parameter int GAP_W  = 8
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        chan_mask,
    input  logic [GAP_W-1:0]  gap_cycles,
    input  logic              clr_ovr,
    output logic              adc_en,
    output logic              adc_chan,
    input  logic [BYTE_W-1:0] adc_data,
    input  logic              adc_done,
    output logic [BYTE_W-1:0] smp_data,
    output logic              smp_chan,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic              overrun,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, CONVERT, GAP} state_t;
    state_t state, state_n;
    logic cur_chan, cur_n, prev_chan, prev_chan_n, prev_valid, prev_valid_n;
    logic stop_pend, stop_n, done_q, done_edge, push, drop;
    logic [GAP_W-1:0] gap_cnt, gap_n;
    assign done_edge = adc_done & ~done_q;
    assign drop = push & smp_valid & ~smp_ready;
    always_comb begin
        state_n = state;
        cur_n = cur_chan;
        prev_chan_n = prev_chan;
        prev_valid_n = prev_valid;
        gap_n = gap_cnt;
        push = 1'b0;
        if (state == IDLE) begin
            if (start && chan_mask != 2'b00) begin
                state_n = CONVERT;
                cur_n = ~chan_mask[0];
                prev_valid_n = 1'b0;
            end
        end else if (state == CONVERT) begin
            if (done_edge) begin
                push = prev_valid;
                prev_chan_n = cur_chan;
                prev_valid_n = 1'b1;
                cur_n = chan_mask[~cur_chan] ? ~cur_chan : cur_chan;
                gap_n = '0;
                state_n = (stop_pend || chan_mask == 2'b00) ? IDLE : GAP;
            end
        end else if (gap_cnt == gap_cycles) begin
            state_n = stop_pend ? IDLE : CONVERT;
        end else begin
            gap_n = gap_cnt + 1'b1;
        end
        stop_n = (state != IDLE) && (state_n != IDLE) && (stop_pend || stop);
    end
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= IDLE;
            cur_chan <= 1'b0;
            prev_chan <= 1'b0;
            prev_valid <= 1'b0;
            stop_pend <= 1'b0;
            done_q <= 1'b0;
            gap_cnt <= '0;
            adc_en <= 1'b0;
            adc_chan <= 1'b0;
            busy <= 1'b0;
            smp_data <= '0;
            smp_chan <= 1'b0;
            smp_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_n;
            cur_chan <= cur_n;
            prev_chan <= prev_chan_n;
            prev_valid <= prev_valid_n;
            stop_pend <= stop_n;
            done_q <= adc_done;
            gap_cnt <= gap_n;
            adc_en <= state_n == CONVERT;
            adc_chan <= cur_n;
            busy <= state_n != IDLE;
            if (push && !drop) begin
                smp_data <= adc_data;
                smp_chan <= prev_chan;
                smp_valid <= 1'b1;
            end else if (smp_valid && smp_ready) begin
                smp_valid <= 1'b0;
            end
            overrun <= drop | (overrun & ~clr_ovr);
        end
    end
endmodule
